// File: rtl/time_set_ctrl.sv
// time_set_ctrl: manual time-setting mode controller.
// Debounces the mode/inc keys on the 1 kHz strobe, steps RUN -> SET_HOUR ->
// SET_MIN -> SET_SEC -> RUN on mode presses, and emits single-cycle adjust
// strobes with auto-repeat while inc is held. Drives the counter freeze level
// (keep) and the blink mask for the field being edited.
// Build option: define SET_TIMEOUT_EN to return to RUN after TIMEOUT_MS idle
// ticks in a SET state; without it, SET states are left only by mode or reset.
//
// state        | meaning
// -------------+-------------------------------------------
// ST_RUN       | normal counting, keys other than mode ignored
// ST_SET_HOUR  | editing hours, hour digits blink
// ST_SET_MIN   | editing minutes, minute digits blink
// ST_SET_SEC   | editing seconds, second digits blink
module time_set_ctrl #(
   parameter int DEBOUNCE_MS     = 20,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100,
   parameter int BLINK_HALF_MS   = 250,
   parameter int TIMEOUT_MS      = 10000
) (
   input  logic       clk_48mhz,
   input  logic       rst_n,
   input  logic       tick_1khz,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic       adjust_sec,
   output logic       adjust_min,
   output logic       adjust_hour,
   output logic       keep,
   output logic [2:0] blank_mask,
   output logic [1:0] set_mode
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_SEC  = 2'd3
   } state_e;

   localparam int RP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
   localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
   localparam int RP_W   = $clog2(RP_MAX + 1);
   localparam int BL_W   = $clog2(BLINK_HALF_MS + 1);
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
   localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY_MS);
   localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE_MS);
   localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLINK_HALF_MS - 1);

   if (DEBOUNCE_MS < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1 ||
       BLINK_HALF_MS < 1 || TIMEOUT_MS < 1) begin : g_param_check
      $error("time_set_ctrl: all timing parameters must be >= 1");
   end

   // bit 0 = mode key, bit 1 = inc key
   logic [1:0]      sync1_q, sync2_q, deb_q, deb_prev_q;
   logic [DB_W-1:0] db_cnt_q [2];

   state_e          state_q, state_d;
   logic            lock_q, lock_d;
   logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic            phase_q, phase_d;
   logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
   logic [2:0]      adj_q, adj_d;
   logic [2:0]      mask_q, mask_d;
   logic            keep_q;

   logic mode_press, inc_press, in_set, inc_active, rep_fire, strobe, timeout_hit;

   assign mode_press = deb_q[0] & ~deb_prev_q[0];
   assign inc_press  = deb_q[1] & ~deb_prev_q[1];
   assign in_set     = (state_q != ST_RUN);
   // A mode step or timeout in the same cycle swallows any inc activity.
   assign inc_active = in_set & ~lock_q & ~mode_press & ~timeout_hit & deb_q[1];

   // Synchronize both keys and accept a level change only after DEBOUNCE_MS
   // consecutive disagreeing ticks; any agreeing cycle restarts the count.
   always_ff @(posedge clk_48mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
      end else begin
         sync1_q    <= {key_inc, key_mode};
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == deb_q[k]) begin
               db_cnt_q[k] <= '0;
            end else if (tick_1khz) begin
               if (db_cnt_q[k] == DB_LAST) begin
                  deb_q[k]    <= ~deb_q[k];
                  db_cnt_q[k] <= '0;
               end else begin
                  db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
               end
            end
         end
      end
   end

`ifdef SET_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_MS + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MS - 1);
   logic [TO_W-1:0] to_cnt_q;

   assign timeout_hit = in_set & tick_1khz & (to_cnt_q == TO_LAST);

   // Idle-tick counter for SET states; any press restarts it.
   always_ff @(posedge clk_48mhz or negedge rst_n) begin
      if (!rst_n)                                          to_cnt_q <= '0;
      else if (!in_set || mode_press || inc_press || timeout_hit) to_cnt_q <= '0;
      else if (tick_1khz)                                  to_cnt_q <= to_cnt_q + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state, repeat timer, blink phase and registered output values.
   always_comb begin
      state_d = state_q;
      if (timeout_hit) begin
         state_d = ST_RUN;
      end else if (mode_press) begin
         case (state_q)
            ST_RUN:      state_d = ST_SET_HOUR;
            ST_SET_HOUR: state_d = ST_SET_MIN;
            ST_SET_MIN:  state_d = ST_SET_SEC;
            default:     state_d = ST_RUN;
         endcase
      end

      // Held inc must be released before it can act in the new field.
      lock_d = lock_q;
      if (mode_press || timeout_hit) lock_d = 1'b1;
      else if (!deb_q[1])            lock_d = 1'b0;

      rep_fire = inc_active & tick_1khz & (rep_cnt_q == RP_W'(1));
      strobe   = (inc_active & inc_press) | rep_fire;

      rep_cnt_d = '0;
      if (inc_active) begin
         if (inc_press)                        rep_cnt_d = RP_DELAY;
         else if (rep_fire)                    rep_cnt_d = RP_RATE;
         else if (tick_1khz && rep_cnt_q != '0) rep_cnt_d = rep_cnt_q - 1'b1;
         else                                  rep_cnt_d = rep_cnt_q;
      end

      adj_d = 3'b000;
      if (strobe) begin
         case (state_q)
            ST_SET_HOUR: adj_d = 3'b100;
            ST_SET_MIN:  adj_d = 3'b010;
            ST_SET_SEC:  adj_d = 3'b001;
            default:     adj_d = 3'b000;
         endcase
      end

      phase_d  = phase_q;
      bl_cnt_d = bl_cnt_q;
      if (state_d != state_q || strobe || state_d == ST_RUN) begin
         phase_d  = 1'b0;
         bl_cnt_d = '0;
      end else if (tick_1khz) begin
         if (bl_cnt_q == BL_LAST) begin
            phase_d  = ~phase_q;
            bl_cnt_d = '0;
         end else begin
            bl_cnt_d = bl_cnt_q + 1'b1;
         end
      end

      case (state_d)
         ST_SET_HOUR: mask_d = {phase_d, 2'b00};
         ST_SET_MIN:  mask_d = {1'b0, phase_d, 1'b0};
         ST_SET_SEC:  mask_d = {2'b00, phase_d};
         default:     mask_d = 3'b000;
      endcase
   end

   // Mode FSM state and registered outputs.
   always_ff @(posedge clk_48mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         lock_q    <= 1'b0;
         rep_cnt_q <= '0;
         phase_q   <= 1'b0;
         bl_cnt_q  <= '0;
         adj_q     <= 3'b000;
         mask_q    <= 3'b000;
         keep_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_q    <= lock_d;
         rep_cnt_q <= rep_cnt_d;
         phase_q   <= phase_d;
         bl_cnt_q  <= bl_cnt_d;
         adj_q     <= adj_d;
         mask_q    <= mask_d;
         keep_q    <= (state_d != ST_RUN);
      end
   end

   assign adjust_hour = adj_q[2];
   assign adjust_min  = adj_q[1];
   assign adjust_sec  = adj_q[0];
   assign keep        = keep_q;
   assign blank_mask  = mask_q;
   assign set_mode    = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: table-driven key sequences, hand-written
// corner sequences and randomized key activity, all compared every cycle
// against a behavioural model of the key/mode/repeat/blink rules.
module tb_time_set_ctrl;
   localparam int DB = 2, RD = 5, RR = 2, BH = 3, TO = 20;
`ifdef SET_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, km = 1'b0, ki = 1'b0;
   logic adjust_sec, adjust_min, adjust_hour, keep;
   logic [2:0] blank_mask;
   logic [1:0] set_mode;

   time_set_ctrl #(
      .DEBOUNCE_MS(DB), .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR),
      .BLINK_HALF_MS(BH), .TIMEOUT_MS(TO)
   ) dut (
      .clk_48mhz(clk), .rst_n(rst_n), .tick_1khz(tick), .key_mode(km), .key_inc(ki),
      .adjust_sec(adjust_sec), .adjust_min(adjust_min), .adjust_hour(adjust_hour),
      .keep(keep), .blank_mask(blank_mask), .set_mode(set_mode)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cnum = 0, tcount = 0;

   // behavioural model state
   int m_hist0[2], m_hist1[2], m_lvl[2], m_prev[2], m_cnt[2];
   int m_st, m_lock, m_held, m_bt, m_idle;
   logic [2:0] m_adj, m_mask;

   // observation bookkeeping
   int cnt_h, cnt_m, cnt_s;
   bit prev_any;
   int sm_prev, sm_changes, sm_change_cyc;
   int pulse_ticks[$];

   typedef struct {
      bit m; bit i; int n;
      int e_mode; int e_keep; int e_h; int e_m; int e_s;
   } vec_t;
   vec_t tbl[16];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cnum);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_hist0[k] = 0; m_hist1[k] = 0; m_lvl[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
      end
      m_st = 0; m_lock = 0; m_held = 0; m_bt = 0; m_idle = 0;
      m_adj = 3'b000; m_mask = 3'b000;
   endtask

   // Predicts the outputs after the coming clock edge for raw keys m/i and tick t.
   task automatic model_step(input bit m, input bit i, input bit t);
      bit mp, ip, inset, hit, active, strobe;
      int nst, seen;
      mp     = (m_lvl[0] == 1) && (m_prev[0] == 0);
      ip     = (m_lvl[1] == 1) && (m_prev[1] == 0);
      inset  = (m_st != 0);
      hit    = TO_EN && inset && t && (m_idle == TO - 1);
      active = inset && (m_lock == 0) && !mp && !hit && (m_lvl[1] == 1);
      strobe = 1'b0;
      if (active) begin
         if (ip) begin
            strobe = 1'b1;
            m_held = 0;
         end else if (t) begin
            m_held++;
            if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) strobe = 1'b1;
         end
      end
      nst   = hit ? 0 : (mp ? (m_st + 1) % 4 : m_st);
      m_adj = strobe ? (3'b001 << (3 - m_st)) : 3'b000;
      if (mp || hit)       m_lock = 1;
      else if (m_lvl[1] == 0) m_lock = 0;
      if (nst != m_st || strobe || nst == 0) m_bt = 0;
      else if (t)                            m_bt++;
      m_mask = (nst == 0) ? 3'b000 : ((((m_bt / BH) % 2) == 1) ? (3'b001 << (3 - nst)) : 3'b000);
      m_idle = (!inset || mp || ip || hit) ? 0 : m_idle + int'(t);
      m_st   = nst;
      for (int k = 0; k < 2; k++) begin
         seen      = m_hist1[k];
         m_prev[k] = m_lvl[k];
         if (seen == m_lvl[k]) m_cnt[k] = 0;
         else if (t) begin
            m_cnt[k]++;
            if (m_cnt[k] == DB) begin
               m_lvl[k] = seen;
               m_cnt[k] = 0;
            end
         end
         m_hist1[k] = m_hist0[k];
      end
      m_hist0[0] = int'(m);
      m_hist0[1] = int'(i);
   endtask

   task automatic cyc(input bit m, input bit i);
      bit t, any;
      logic [8:0] act_v, exp_v;
      logic [1:0] st2;
      t = (cnum % 10 == 9);
      km = m; ki = i; tick = t;
      if (t) tcount++;
      model_step(m, i, t);
      @(posedge clk); #1;
      cnum++;
      st2   = m_st[1:0];
      act_v = {set_mode, keep, blank_mask, adjust_hour, adjust_min, adjust_sec};
      exp_v = {st2, (m_st != 0), m_mask, m_adj};
      chk("model_outputs", int'(act_v), int'(exp_v));
      any = adjust_hour | adjust_min | adjust_sec;
      if (any) begin
         chk("strobe_onehot", $countones({adjust_hour, adjust_min, adjust_sec}), 1);
         chk("strobe_not_back_to_back", int'(prev_any), 0);
         chk("mask_visible_on_strobe", int'(blank_mask), 0);
      end
      if (adjust_hour) cnt_h++;
      if (adjust_min)  cnt_m++;
      if (adjust_sec) begin
         cnt_s++;
         pulse_ticks.push_back(tcount);
      end
      prev_any = any;
      if (int'(set_mode) != sm_prev) begin
         sm_changes++;
         sm_change_cyc = cnum;
      end
      sm_prev = int'(set_mode);
   endtask

   task automatic hold(input bit m, input bit i, input int n);
      repeat (n) cyc(m, i);
   endtask

   task automatic clear_counts();
      cnt_h = 0; cnt_m = 0; cnt_s = 0;
      pulse_ticks.delete();
   endtask

   task automatic goto_state(input int target);
      int guard = 0;
      while (m_st != target && guard < 8) begin
         hold(1'b1, 1'b0, 40);
         hold(1'b0, 1'b0, 40);
         guard++;
      end
      chk("goto_state", int'(set_mode), target);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_set_mode"}, int'(set_mode), 0);
      chk({tag, "_keep"}, int'(keep), 0);
      chk({tag, "_blank_mask"}, int'(blank_mask), 0);
      chk({tag, "_adjust"}, int'({adjust_hour, adjust_min, adjust_sec}), 0);
   endtask

   initial begin
      int off[5];
      bit rm, ri;
      int rn, start_cyc;

      tbl[0]  = '{1'b1, 1'b0, 40, 1, 1, 0, 0, 0};
      tbl[1]  = '{1'b0, 1'b0, 40, 1, 1, 0, 0, 0};
      tbl[2]  = '{1'b0, 1'b1, 30, 1, 1, 1, 0, 0};
      tbl[3]  = '{1'b0, 1'b0, 40, 1, 1, 0, 0, 0};
      tbl[4]  = '{1'b1, 1'b0, 40, 2, 1, 0, 0, 0};
      tbl[5]  = '{1'b0, 1'b0, 40, 2, 1, 0, 0, 0};
      tbl[6]  = '{1'b0, 1'b1, 30, 2, 1, 0, 1, 0};
      tbl[7]  = '{1'b0, 1'b0, 40, 2, 1, 0, 0, 0};
      tbl[8]  = '{1'b1, 1'b0, 40, 3, 1, 0, 0, 0};
      tbl[9]  = '{1'b0, 1'b0, 40, 3, 1, 0, 0, 0};
      tbl[10] = '{1'b0, 1'b1, 30, 3, 1, 0, 0, 1};
      tbl[11] = '{1'b0, 1'b0, 40, 3, 1, 0, 0, 0};
      tbl[12] = '{1'b1, 1'b0, 40, 0, 0, 0, 0, 0};
      tbl[13] = '{1'b0, 1'b0, 40, 0, 0, 0, 0, 0};
      tbl[14] = '{1'b0, 1'b1, 30, 0, 0, 0, 0, 0};
      tbl[15] = '{1'b0, 1'b0, 40, 0, 0, 0, 0, 0};
      off[0] = 0; off[1] = 5; off[2] = 7; off[3] = 9; off[4] = 11;

      prev_any = 1'b0; sm_prev = 0; sm_changes = 0; sm_change_cyc = 0;
      clear_counts();
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;

      // table-driven key sequences through every state
      foreach (tbl[e]) begin
         clear_counts();
         hold(tbl[e].m, tbl[e].i, tbl[e].n);
         chk($sformatf("tbl%0d_set_mode", e), int'(set_mode), tbl[e].e_mode);
         chk($sformatf("tbl%0d_keep", e), int'(keep), tbl[e].e_keep);
         chk($sformatf("tbl%0d_adj_hour", e), cnt_h, tbl[e].e_h);
         chk($sformatf("tbl%0d_adj_min", e), cnt_m, tbl[e].e_m);
         chk($sformatf("tbl%0d_adj_sec", e), cnt_s, tbl[e].e_s);
      end

      // bouncing mode key, then a clean hold: exactly one step ~2 ticks later
      sm_changes = 0;
      for (int b = 0; b < 8; b++) hold(b[0] ? 1'b0 : 1'b1, 1'b0, 5);
      start_cyc = cnum;
      hold(1'b1, 1'b0, 60);
      chk("bounce_single_step", sm_changes, 1);
      chk("bounce_set_mode", int'(set_mode), 1);
      chk("bounce_latency_window",
          int'((sm_change_cyc - start_cyc) >= 12 && (sm_change_cyc - start_cyc) <= 35), 1);
      hold(1'b0, 1'b0, 40);

      // auto-repeat in SET_SEC: 12 ticks held -> strobes at 0,5,7,9,11
      goto_state(3);
      clear_counts();
      hold(1'b0, 1'b1, 120);
      hold(1'b0, 1'b0, 40);
      chk("repeat_count", cnt_s, 5);
      for (int j = 1; j < 5; j++)
         if (pulse_ticks.size() > j)
            chk($sformatf("repeat_offset%0d", j), pulse_ticks[j] - pulse_ticks[0], off[j]);

      // simultaneous mode+inc in SET_HOUR: mode wins, held inc is locked out
      goto_state(1);
      clear_counts();
      hold(1'b1, 1'b1, 40);
      chk("simul_set_mode", int'(set_mode), 2);
      chk("simul_no_adjust", cnt_h + cnt_m + cnt_s, 0);
      hold(1'b0, 1'b1, 60);
      chk("simul_locked_no_repeat", cnt_h + cnt_m + cnt_s, 0);
      hold(1'b0, 1'b0, 40);
      hold(1'b0, 1'b1, 30);
      hold(1'b0, 1'b0, 40);
      chk("simul_repress_adj_min", cnt_m, 1);
      chk("simul_repress_others", cnt_h + cnt_s, 0);

      // inactivity in SET_HOUR
      goto_state(1);
      hold(1'b0, 1'b0, 1000);
      if (TO_EN) begin
         chk("timeout_set_mode", int'(set_mode), 0);
         chk("timeout_keep", int'(keep), 0);
      end else begin
         chk("no_timeout_set_mode", int'(set_mode), 1);
         chk("no_timeout_keep", int'(keep), 1);
      end

      // reset asserted mid-SET_MIN with inc activity in flight
      goto_state(2);
      hold(1'b0, 1'b1, 24);
      km = 1'b0; ki = 1'b0; tick = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midrst");
      model_reset();
      @(posedge clk); #1;
      check_zero_outputs("midrst_hold");
      rst_n = 1'b1;
      prev_any = 1'b0; sm_prev = 0;

      // randomized key activity against the model
      for (int r = 0; r < 70; r++) begin
         rm = ($urandom_range(0, 2) == 0);
         ri = ($urandom_range(0, 1) == 1);
         rn = $urandom_range(1, 70);
         hold(rm, ri, rn);
      end
      hold(1'b0, 1'b0, 50);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
